// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty ramp controller: default duty width,
// full-scale duty value and the controller FSM state encoding.
package pwm_pkg;

   localparam int BITS_DUTY_DEFAULT = 3;
   localparam int DUTY_W            = BITS_DUTY_DEFAULT + 1;
   localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(1 << BITS_DUTY_DEFAULT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Request channel carrying a new target duty into the ramp controller.
interface pwm_ramp_ctrl_if
   import pwm_pkg::*;
#(
   parameter int DUTY_W = pwm_pkg::DUTY_W
) ();

   // A transfer happens on every rising edge where req_valid && req_ready.
   // The requester holds req_valid and req_target stable until that edge;
   // req_ready never depends combinationally on req_valid.
   logic              req_valid;
   logic [DUTY_W-1:0] req_target;
   logic              req_ready;

   modport master (
      output req_valid,
      output req_target,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_target,
      output req_ready
   );

endinterface

// File: rtl/pwm_step_timer.sv
// Counts PWM periods and flags the tick on which a one-LSB duty step is due.
module pwm_step_timer #(
   parameter int STEP_PERIODS = 4
) (
   input  logic clk_in,
   input  logic rst,
   input  logic clear_i,
   input  logic tick_i,
   output logic tc_o
);

   localparam logic [7:0] LAST = 8'(STEP_PERIODS - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   assign tc_o = tick_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || tc_o) begin
         cnt_d = '0;
      end else if (tick_i) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramps a registered PWM duty toward a requested target, one LSB every
// STEP_PERIODS PWM periods, changing duty only on period boundaries.
module pwm_ramp_ctrl
   import pwm_pkg::*;
#(
   parameter int BITS_duty    = BITS_DUTY_DEFAULT,
   parameter int STEP_PERIODS = 4
) (
   input  logic               clk_in,
   input  logic               rst,
   input  logic               period_tick,
   input  logic               abort,
   pwm_ramp_ctrl_if.slave     req_if,
   output logic [BITS_duty:0] duty,
   output logic               busy,
   output logic               done,
   output state_e             state_o
);

   localparam int DW = BITS_duty + 1;
   localparam logic [DW-1:0] DMAX = {1'b1, {BITS_duty{1'b0}}};

   state_e          state_q;
   state_e          state_d;
   logic [DW-1:0]   duty_q;
   logic [DW-1:0]   duty_d;
   logic [DW-1:0]   target_q;
   logic [DW-1:0]   target_d;
   logic [DW-1:0]   clamped;
   logic            done_q;
   logic            done_d;
   logic            step_tc;

   assign clamped = (req_if.req_target > DMAX) ? DMAX : req_if.req_target;

   // Counter only runs during a ramp, so it starts from zero on every transfer.
   pwm_step_timer #(
      .STEP_PERIODS (STEP_PERIODS)
   ) u_step_timer (
      .clk_in  (clk_in),
      .rst     (rst),
      .clear_i (state_q != ST_RAMP),
      .tick_i  (period_tick),
      .tc_o    (step_tc)
   );

   always_comb begin
      state_d  = state_q;
      duty_d   = duty_q;
      target_d = target_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_if.req_valid) begin
               target_d = clamped;
               state_d  = (clamped == duty_q) ? ST_DONE : ST_RAMP;
            end
         end
         ST_RAMP: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (step_tc) begin
               duty_d = (target_q > duty_q) ? duty_q + 1'b1 : duty_q - 1'b1;
               if (duty_d == target_q) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         duty_q   <= '0;
         target_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         duty_q   <= duty_d;
         target_q <= target_d;
         done_q   <= done_d;
      end
   end

   assign req_if.req_ready = (state_q == ST_IDLE);
   assign busy             = (state_q == ST_RAMP);
   assign done             = done_q;
   assign duty             = duty_q;
   assign state_o          = state_q;

endmodule
